// File: rtl/ir_sweep_pkg.sv
// Shared types and constants for the IR sweep scheduler.
// States, sensor pairs, A2D channel map and error weights.
package ir_sweep_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        CNV_L,
        WAIT_L,
        CNV_R,
        WAIT_R,
        CNV_B,
        WAIT_B,
        CALC
    } state_t;

    typedef enum logic [1:0] {
        INNER,
        MID,
        OUTER
    } pair_t;

    typedef logic [2:0] chnl_t;

    localparam chnl_t LFT_IN  = 3'd1;
    localparam chnl_t RHT_IN  = 3'd0;
    localparam chnl_t LFT_MID = 3'd4;
    localparam chnl_t RHT_MID = 3'd2;
    localparam chnl_t LFT_OUT = 3'd3;
    localparam chnl_t RHT_OUT = 3'd7;
    localparam chnl_t BATT    = 3'd5;

    localparam int W_IN  = 0;
    localparam int W_MID = 1;
    localparam int W_OUT = 2;

    function automatic chnl_t lft_ch(input pair_t p);
        case (p)
            INNER:   return LFT_IN;
            MID:     return LFT_MID;
            default: return LFT_OUT;
        endcase
    endfunction

    function automatic chnl_t rht_ch(input pair_t p);
        case (p)
            INNER:   return RHT_IN;
            MID:     return RHT_MID;
            default: return RHT_OUT;
        endcase
    endfunction

endpackage

// File: rtl/ir_sweep_sched_if.sv
// Request/response bundle between the sweep scheduler and the A2D master.
// master = scheduler side, slave = A2D side.
interface ir_sweep_sched_if;
    import ir_sweep_pkg::*;

    logic        strt_cnv;
    chnl_t       chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  res
    );

    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output res
    );

endinterface

// File: rtl/ir_err_calc.sv
// Weighted line-position error: (rI-lI) + 2*(rM-lM) + 4*(rO-lO).
// Purely combinational; worst case +/-28665 fits 16-bit signed.
module ir_err_calc
    import ir_sweep_pkg::*;
(
    input  logic [11:0]        lft_in,
    input  logic [11:0]        rht_in,
    input  logic [11:0]        lft_mid,
    input  logic [11:0]        rht_mid,
    input  logic [11:0]        lft_out,
    input  logic [11:0]        rht_out,
    output logic signed [15:0] error
);

    logic signed [12:0] d_in, d_mid, d_out;
    logic signed [15:0] x_in, x_mid, x_out;

    assign d_in  = $signed({1'b0, rht_in})  - $signed({1'b0, lft_in});
    assign d_mid = $signed({1'b0, rht_mid}) - $signed({1'b0, lft_mid});
    assign d_out = $signed({1'b0, rht_out}) - $signed({1'b0, lft_out});

    assign x_in  = {{3{d_in[12]}},  d_in};
    assign x_mid = {{3{d_mid[12]}}, d_mid};
    assign x_out = {{3{d_out[12]}}, d_out};

    assign error = (x_in <<< W_IN) + (x_mid <<< W_MID) + (x_out <<< W_OUT);

endmodule

// File: rtl/ir_sweep_sched.sv
// IR emitter / A2D sweep sequencer producing a signed steering error.
// Define IR_SWEEP_BATT_EN to add a battery conversion and batt output.
module ir_sweep_sched
    import ir_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 4096,
    parameter int TMO_CYC    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    ir_sweep_sched_if.master   a2d,
    output logic               IR_in_en,
    output logic               IR_mid_en,
    output logic               IR_out_en,
    output logic signed [15:0] error,
    output logic               err_vld,
    output logic               fault
`ifdef IR_SWEEP_BATT_EN
    ,
    output logic [11:0]        batt
`endif
);

    localparam int CW = $clog2(SETTLE_CYC + TMO_CYC) + 1;

    state_t             state, nxt_state;
    pair_t              pair, nxt_pair;
    logic [CW-1:0]      cnt;
    logic [11:0]        lft [3];
    logic [11:0]        rht [3];
    logic [2:0]         en, nxt_en;
    logic               tmo;
    logic signed [15:0] calc;
`ifdef IR_SWEEP_BATT_EN
    logic [11:0]        batt_q;
`endif

    ir_err_calc u_calc (
        .lft_in  (lft[INNER]),
        .rht_in  (rht[INNER]),
        .lft_mid (lft[MID]),
        .rht_mid (rht[MID]),
        .lft_out (lft[OUTER]),
        .rht_out (rht[OUTER]),
        .error   (calc)
    );

    // Next state, A2D request decode and next emitter pattern
    always_comb begin
        nxt_state    = state;
        nxt_pair     = pair;
        a2d.strt_cnv = 1'b0;
        a2d.chnnl    = '0;
        tmo          = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    nxt_state = SETTLE;
                    nxt_pair  = INNER;
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYC - 1))
                    nxt_state = CNV_L;
            end
            CNV_L: begin
                a2d.strt_cnv = 1'b1;
                a2d.chnnl    = lft_ch(pair);
                nxt_state    = WAIT_L;
            end
            WAIT_L: begin
                a2d.chnnl = lft_ch(pair);
                if (a2d.cnv_cmplt) begin
                    nxt_state = CNV_R;
                end else if (cnt == CW'(TMO_CYC - 1)) begin
                    tmo       = 1'b1;
                    nxt_state = IDLE;
                end
            end
            CNV_R: begin
                a2d.strt_cnv = 1'b1;
                a2d.chnnl    = rht_ch(pair);
                nxt_state    = WAIT_R;
            end
            WAIT_R: begin
                a2d.chnnl = rht_ch(pair);
                if (a2d.cnv_cmplt) begin
                    if (pair == OUTER) begin
`ifdef IR_SWEEP_BATT_EN
                        nxt_state = CNV_B;
`else
                        nxt_state = CALC;
`endif
                    end else begin
                        nxt_state = SETTLE;
                        nxt_pair  = pair_t'(pair + 2'd1);
                    end
                end else if (cnt == CW'(TMO_CYC - 1)) begin
                    tmo       = 1'b1;
                    nxt_state = IDLE;
                end
            end
            CNV_B: begin
                a2d.strt_cnv = 1'b1;
                a2d.chnnl    = BATT;
                nxt_state    = WAIT_B;
            end
            WAIT_B: begin
                a2d.chnnl = BATT;
                if (a2d.cnv_cmplt) begin
                    nxt_state = CALC;
                end else if (cnt == CW'(TMO_CYC - 1)) begin
                    tmo       = 1'b1;
                    nxt_state = IDLE;
                end
            end
            CALC: begin
                if (go) begin
                    nxt_state = SETTLE;
                    nxt_pair  = INNER;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        nxt_en = 3'b000;
        if (nxt_state inside {SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R})
            nxt_en = 3'b001 << nxt_pair;
    end

    // State and pair registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pair  <= INNER;
        end else begin
            state <= nxt_state;
            pair  <= nxt_pair;
        end
    end

    // Shared settle/timeout counter, restarted on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (nxt_state != state || state == IDLE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Capture conversion results for the current pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft <= '{default: '0};
            rht <= '{default: '0};
        end else if (a2d.cnv_cmplt) begin
            if (state == WAIT_L)
                lft[pair] <= a2d.res;
            if (state == WAIT_R)
                rht[pair] <= a2d.res;
        end
    end

    // Registered emitter enables so they switch cleanly on transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            en <= 3'b000;
        else
            en <= nxt_en;
    end

    assign IR_in_en  = en[0];
    assign IR_mid_en = en[1];
    assign IR_out_en = en[2];

    // Publish error on CALC; timeout raises the sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error   <= '0;
            err_vld <= 1'b0;
            fault   <= 1'b0;
        end else begin
            err_vld <= (state == CALC);
            if (state == CALC) begin
                error <= calc;
                fault <= 1'b0;
            end else if (tmo) begin
                fault <= 1'b1;
            end
        end
    end

`ifdef IR_SWEEP_BATT_EN
    // Battery sample, exposed together with the error update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batt_q <= '0;
            batt   <= '0;
        end else begin
            if (state == WAIT_B && a2d.cnv_cmplt)
                batt_q <= a2d.res;
            if (state == CALC)
                batt <= batt_q;
        end
    end
`endif

endmodule
